// File: rtl/ddr_data_sched.sv
// DQ/DQS bus calendar for the DDR4 controller: books write/read data windows at their
// fixed CAS latency, flags collisions one cycle ahead and drives the datapath start pulses.
module ddr_data_sched #(
    parameter int unsigned AL        = 0,
    parameter int unsigned CWL       = 9,
    parameter int unsigned CL        = 11,
    parameter int unsigned CAL_DEPTH = 32
) (
    input  logic       CK_t,
    input  logic       reset,
    input  logic       wr_cmd,
    input  logic       rd_cmd,
    input  logic [3:0] BL,
    input  logic [1:0] WR_PRE,
    input  logic [1:0] RD_PRE,
    output logic       wr_ok,
    output logic       rd_ok,
    output logic       wr_rdy,
    output logic       rd_rdy,
    output logic       bus_wr,
    output logic       bus_rd,
    output logic [3:0] inflight,
    output logic       err_coll
);

    localparam int unsigned MaxLat = (CL > CWL) ? CL : CWL;

    if (CAL_DEPTH < AL + MaxLat + 2 + 8 / 2 + 1) begin : g_depth_chk
        $error("ddr_data_sched: CAL_DEPTH too small for AL/CWL/CL");
    end

    logic [CAL_DEPTH-1:0] r_occ, r_dir, r_st, r_en;
    logic [3:0]           r_inflight;
    logic                 r_err;

    logic [CAL_DEPTH-1:0] w_occ_s, w_dir_s, w_st_s, w_en_s;
    logic [CAL_DEPTH-1:0] w_occ_d, w_dir_d, w_st_d, w_en_d;
    logic [CAL_DEPTH-1:0] w_wr_win, w_wr_wide, w_wr_st, w_wr_en;
    logic [CAL_DEPTH-1:0] w_rd_win, w_rd_wide, w_rd_st, w_rd_en;
    logic [3:0]           w_inflight_d;
    int                   w_nd, w_lw, w_nw, w_lr, w_nr;
    logic                 w_wr_pre_ok, w_rd_pre_ok;
    logic                 w_wr_coll, w_rd_coll;
    logic                 w_acc_wr, w_acc_rd, w_acc, w_drop;

    // Checks run against the calendar as it will look after the next shift.
    assign w_occ_s = r_occ >> 1;
    assign w_dir_s = r_dir >> 1;
    assign w_st_s  = r_st >> 1;
    assign w_en_s  = r_en >> 1;

    assign w_nd = (BL == 4'd4) ? 2 : 4;
    assign w_lw = int'(AL + CWL) - int'(WR_PRE);
    assign w_nw = int'(WR_PRE) + w_nd;
    assign w_lr = int'(AL + CL) - int'(RD_PRE);
    assign w_nr = int'(RD_PRE) + w_nd;

    assign w_wr_pre_ok = (WR_PRE == 2'd1) || (WR_PRE == 2'd2);
    assign w_rd_pre_ok = (RD_PRE == 2'd1) || (RD_PRE == 2'd2);

    for (genvar k = 0; k < CAL_DEPTH; k++) begin : g_mask
        assign w_wr_win[k]  = (k >= w_lw) && (k < w_lw + w_nw);
        assign w_wr_wide[k] = (k >= w_lw - 1) && (k <= w_lw + w_nw);
        assign w_wr_st[k]   = (k == w_lw);
        assign w_wr_en[k]   = (k == w_lw + w_nw - 1);
        assign w_rd_win[k]  = (k >= w_lr) && (k < w_lr + w_nr);
        assign w_rd_wide[k] = (k >= w_lr - 1) && (k <= w_lr + w_nr);
        assign w_rd_st[k]   = (k == w_lr);
        assign w_rd_en[k]   = (k == w_lr + w_nr - 1);
    end

    // A same-direction window may start on the slot where the previous one ends.
    assign w_wr_coll = (|(w_occ_s & w_wr_win & ~(w_wr_st & w_en_s & w_dir_s)))
                     | (|(w_occ_s & ~w_dir_s & w_wr_wide));
    assign w_rd_coll = (|(w_occ_s & w_rd_win & ~(w_rd_st & w_en_s & ~w_dir_s)))
                     | (|(w_occ_s & w_dir_s & w_rd_wide));

    assign wr_ok = w_wr_pre_ok && !w_wr_coll;
    assign rd_ok = w_rd_pre_ok && !w_rd_coll;

    assign w_acc_wr = wr_cmd && !rd_cmd && wr_ok;
    assign w_acc_rd = rd_cmd && !wr_cmd && rd_ok;
    assign w_acc    = w_acc_wr || w_acc_rd;
    assign w_drop   = (wr_cmd || rd_cmd) && !w_acc;

    assign w_occ_d = w_occ_s | ({CAL_DEPTH{w_acc_wr}} & w_wr_win)
                             | ({CAL_DEPTH{w_acc_rd}} & w_rd_win);
    assign w_dir_d = w_dir_s | ({CAL_DEPTH{w_acc_wr}} & w_wr_win);
    assign w_st_d  = w_st_s  | ({CAL_DEPTH{w_acc_wr}} & w_wr_st)
                             | ({CAL_DEPTH{w_acc_rd}} & w_rd_st);
    assign w_en_d  = w_en_s  | ({CAL_DEPTH{w_acc_wr}} & w_wr_en)
                             | ({CAL_DEPTH{w_acc_rd}} & w_rd_en);

    always_comb begin
        w_inflight_d = r_inflight;
        if (w_acc && !r_en[0] && (r_inflight != 4'd15)) begin
            w_inflight_d = r_inflight + 4'd1;
        end else if (!w_acc && r_en[0] && (r_inflight != 4'd0)) begin
            w_inflight_d = r_inflight - 4'd1;
        end
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            r_occ      <= '0;
            r_dir      <= '0;
            r_st       <= '0;
            r_en       <= '0;
            r_inflight <= 4'd0;
            r_err      <= 1'b0;
        end else begin
            r_occ      <= w_occ_d;
            r_dir      <= w_dir_d;
            r_st       <= w_st_d;
            r_en       <= w_en_d;
            r_inflight <= w_inflight_d;
            r_err      <= r_err | w_drop;
        end
    end

    assign bus_wr   = r_occ[0] & r_dir[0];
    assign bus_rd   = r_occ[0] & ~r_dir[0];
    assign wr_rdy   = r_st[0] & r_dir[0];
    assign rd_rdy   = r_st[0] & ~r_dir[0];
    assign inflight = r_inflight;
    assign err_coll = r_err;

endmodule

// File: tb/tb_ddr_data_sched.sv
// Scoreboard bench for ddr_data_sched: an absolute-time bus model predicts acceptance,
// start pulses and bus ownership; expected start pulses are queued and matched on output.
module tb_ddr_data_sched;

    localparam int AL      = 0;
    localparam int CWL     = 9;
    localparam int CL      = 11;
    localparam int DEPTH   = 32;
    localparam int HORIZON = 400;

    logic       CK_t   = 1'b0;
    logic       reset  = 1'b1;
    logic       wr_cmd = 1'b0;
    logic       rd_cmd = 1'b0;
    logic [3:0] BL     = 4'd8;
    logic [1:0] WR_PRE = 2'd1;
    logic [1:0] RD_PRE = 2'd1;
    logic       wr_ok, rd_ok, wr_rdy, rd_rdy, bus_wr, bus_rd, err_coll;
    logic [3:0] inflight;

    ddr_data_sched #(
        .AL       (AL),
        .CWL      (CWL),
        .CL       (CL),
        .CAL_DEPTH(DEPTH)
    ) u_dut (
        .CK_t    (CK_t),
        .reset   (reset),
        .wr_cmd  (wr_cmd),
        .rd_cmd  (rd_cmd),
        .BL      (BL),
        .WR_PRE  (WR_PRE),
        .RD_PRE  (RD_PRE),
        .wr_ok   (wr_ok),
        .rd_ok   (rd_ok),
        .wr_rdy  (wr_rdy),
        .rd_rdy  (rd_rdy),
        .bus_wr  (bus_wr),
        .bus_rd  (bus_rd),
        .inflight(inflight),
        .err_coll(err_coll)
    );

    always #5 CK_t = ~CK_t;

    typedef struct {
        int edge_n;
        bit is_wr;
    } ev_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    bit  mon_en = 1'b0;
    bit  exp_err = 1'b0;
    bit  exp_wr[HORIZON];
    bit  exp_rd[HORIZON];
    bit  exp_wr_end[HORIZON];
    bit  exp_rd_end[HORIZON];
    ev_t sb_q[$];

    // Edge counter: cyc == n during the cycle that begins at rising edge n.
    always @(posedge CK_t) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CK_t);
        #1;
    endtask

    task automatic goto_edge(input int t);
        while (cyc < t - 1) step();
    endtask

    function automatic int lat(input bit w, input int pre);
        return w ? (AL + CWL - pre) : (AL + CL - pre);
    endfunction

    function automatic int wlen(input int pre, input int bl);
        return pre + ((bl == 4) ? 2 : 4);
    endfunction

    // Would a command sampled at edge te fit on the bus?
    function automatic bit model_ok(input bit w, input int te, input int pre, input int bl);
        int s, n;
        if (pre != 1 && pre != 2) return 1'b0;
        s = te + lat(w, pre);
        n = wlen(pre, bl);
        for (int e = s; e < s + n; e++) begin
            if (exp_wr[e] || exp_rd[e]) begin
                if (!(e == s && (w ? (exp_wr_end[e] && exp_wr[e]) : (exp_rd_end[e] && exp_rd[e]))))
                    return 1'b0;
            end
        end
        if (w) return !(exp_rd[s - 1] || exp_rd[s + n]);
        return !(exp_wr[s - 1] || exp_wr[s + n]);
    endfunction

    task automatic issue(input bit w, input bit r, input int pre, input int bl);
        int  te, s, n;
        bit  okw, okr, acc;
        te     = cyc + 1;
        wr_cmd = w;
        rd_cmd = r;
        BL     = 4'(bl);
        if (w) WR_PRE = 2'(pre);
        if (r) RD_PRE = 2'(pre);
        #1;
        okw = model_ok(1'b1, te, int'(WR_PRE), bl);
        okr = model_ok(1'b0, te, int'(RD_PRE), bl);
        check("wr_ok", int'(wr_ok), int'(okw));
        check("rd_ok", int'(rd_ok), int'(okr));
        acc = (w ^ r) && (w ? okw : okr);
        step();
        wr_cmd = 1'b0;
        rd_cmd = 1'b0;
        if (acc) begin
            s = te + lat(w, pre);
            n = wlen(pre, bl);
            for (int e = s; e < s + n; e++) begin
                if (w) exp_wr[e] = 1'b1;
                else   exp_rd[e] = 1'b1;
            end
            if (w) exp_wr_end[s + n - 1] = 1'b1;
            else   exp_rd_end[s + n - 1] = 1'b1;
            sb_q.push_back('{edge_n: s, is_wr: w});
        end else begin
            exp_err = 1'b1;
        end
        check("err_coll", int'(err_coll), int'(exp_err));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_bus_wr"}, int'(bus_wr), 0);
        check({tag, "_bus_rd"}, int'(bus_rd), 0);
        check({tag, "_wr_rdy"}, int'(wr_rdy), 0);
        check({tag, "_rd_rdy"}, int'(rd_rdy), 0);
        check({tag, "_inflight"}, int'(inflight), 0);
        check({tag, "_err_coll"}, int'(err_coll), 0);
        check({tag, "_wr_ok"}, int'(wr_ok), 1);
        check({tag, "_rd_ok"}, int'(rd_ok), 1);
    endtask

    // Asserted mid-cycle, so outputs must clear without waiting for an edge.
    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check_cleared(tag);
        for (int e = 0; e < HORIZON; e++) begin
            exp_wr[e]     = 1'b0;
            exp_rd[e]     = 1'b0;
            exp_wr_end[e] = 1'b0;
            exp_rd_end[e] = 1'b0;
        end
        sb_q.delete();
        exp_err = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    always @(negedge CK_t) begin
        ev_t ev;
        if (mon_en && !reset) begin
            if (sb_q.size() > 0 && sb_q[0].edge_n < cyc) begin
                ev = sb_q.pop_front();
                check("rdy_missing", cyc, ev.edge_n);
            end
            if (wr_rdy || rd_rdy) begin
                check("rdy_exclusive", int'(wr_rdy && rd_rdy), 0);
                if (sb_q.size() == 0) begin
                    check("rdy_unexpected", 1, 0);
                end else begin
                    ev = sb_q.pop_front();
                    check("rdy_edge", cyc, ev.edge_n);
                    check("rdy_dir", int'(wr_rdy), int'(ev.is_wr));
                end
            end
            check("bus_wr", int'(bus_wr), int'(exp_wr[cyc]));
            check("bus_rd", int'(bus_rd), int'(exp_rd[cyc]));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        step();
        step();
        check_cleared("rst");
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single BL8 write: start pulse 8 edges later, 5-cycle window.
        goto_edge(10);
        issue(1'b1, 1'b0, 1, 8);
        check("single_inflight_acc", int'(inflight), 1);
        goto_edge(22);
        check("single_inflight_busy", int'(inflight), 1);
        goto_edge(24);
        check("single_inflight_done", int'(inflight), 0);

        // Back-to-back writes chain into one continuous bus occupancy.
        goto_edge(40);
        issue(1'b1, 1'b0, 1, 8);
        goto_edge(44);
        issue(1'b1, 1'b0, 1, 8);
        check("b2b_inflight", int'(inflight), 2);
        check("b2b_err", int'(err_coll), 0);

        // Write then read: read 3 edges later lands on the turnaround gap, 4 later fits.
        goto_edge(70);
        issue(1'b1, 1'b0, 1, 8);
        goto_edge(73);
        BL     = 4'd8;
        RD_PRE = 2'd1;
        #1;
        check("turn_k3_rd_ok", int'(rd_ok), 0);
        issue(1'b0, 1'b1, 1, 8);
        check("turn_k3_err", int'(err_coll), 1);
        issue(1'b0, 1'b1, 1, 8);
        check("turn_k4_inflight", int'(inflight), 2);

        goto_edge(95);
        apply_reset("rst_idle");

        // Simultaneous write and read are both dropped.
        goto_edge(100);
        issue(1'b1, 1'b0, 1, 8);
        goto_edge(102);
        issue(1'b1, 1'b1, 1, 8);
        check("dual_inflight", int'(inflight), 1);
        check("dual_err", int'(err_coll), 1);

        goto_edge(115);
        apply_reset("rst_err");

        // BC4 write with a 2-cycle preamble: 7-edge latency, 4-cycle window.
        goto_edge(130);
        issue(1'b1, 1'b0, 2, 4);

        // Reset two cycles into a write window, then a fresh write.
        goto_edge(160);
        issue(1'b1, 1'b0, 1, 8);
        goto_edge(162);
        issue(1'b1, 1'b1, 1, 8);
        goto_edge(171);
        check("mid_bus_wr", int'(bus_wr), 1);
        check("mid_inflight", int'(inflight), 1);
        apply_reset("rst_mid");
        goto_edge(182);
        issue(1'b1, 1'b0, 1, 8);
        check("fresh_inflight", int'(inflight), 1);
        goto_edge(196);
        check("fresh_inflight_done", int'(inflight), 0);

        goto_edge(205);
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
